// File: rtl/note_sequencer.sv
// note_sequencer: steps a 16-entry note table at a fixed tempo and drives the oscillator note select and gate.
// Ports: i_clk/i_rst clock and async active-high reset; i_start/i_stop level-sampled play control;
// i_loop restarts after the final step; i_last_step final step index latched at start;
// i_wr_en/i_wr_addr/i_wr_data table write {rest, note}, honoured only while idle;
// o_note_sel note index, o_gate note sounding, o_step current step, o_busy playing,
// o_done one-cycle pulse when a one-shot pattern runs to its end.
module note_sequencer #(
  parameter int STEP_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 625_000,
  parameter int PATTERN_LEN = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_loop,
  input  logic [3:0] i_last_step,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_addr,
  input  logic [2:0] i_wr_data,
  output logic [1:0] o_note_sel,
  output logic       o_gate,
  output logic [3:0] o_step,
  output logic       o_busy,
  output logic       o_done
);
  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] ON_CNT = CW'(STEP_CYCLES - GAP_CYCLES);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t r_state, w_state;
  logic [2:0] r_tab [PATTERN_LEN];
  logic [CW-1:0] r_cnt, w_cnt;
  logic [3:0] r_step, w_step, r_last, w_last;
  logic [1:0] r_note, w_note;
  logic r_gate, w_gate, r_done, w_done, r_busy, r_rest, w_rest, w_load;
  logic [2:0] w_entry;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_step = r_step;
    w_last = r_last;
    w_done = 1'b0;
    w_load = 1'b0;
    if (r_state == IDLE) begin
      if (i_start && !i_stop) begin
        w_state = PLAY;
        w_last = i_last_step;
        w_step = '0;
        w_cnt = '0;
        w_load = 1'b1;
      end
    end else if (i_stop) begin
      w_state = IDLE;
      w_step = '0;
      w_cnt = '0;
    end else if (r_cnt == LAST_CNT) begin
      w_cnt = '0;
      w_load = 1'b1;
      if (r_step < r_last) w_step = r_step + 4'd1;
      else begin
        w_step = '0;
        if (!i_loop) begin
          w_state = IDLE;
          w_done = 1'b1;
          w_load = 1'b0;
        end
      end
    end else w_cnt = r_cnt + 1'b1;
    w_entry = r_tab[w_step];
    // The rest flag is captured at step load so a table write landing on the
    // start edge cannot change the step already in progress.
    w_rest = w_load ? w_entry[2] : r_rest;
    // Rests keep the previous note so the oscillator is never retuned needlessly.
    w_note = (w_load && !w_entry[2]) ? w_entry[1:0] : r_note;
    w_gate = (w_state == PLAY) && !w_rest && (GAP_CYCLES == 0 || w_cnt < ON_CNT);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_step <= '0;
      r_last <= '0;
      r_note <= '0;
      r_gate <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_rest <= 1'b1;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_step <= w_step;
      r_last <= w_last;
      r_note <= w_note;
      r_gate <= w_gate;
      r_done <= w_done;
      r_busy <= (w_state == PLAY);
      r_rest <= w_rest;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < PATTERN_LEN; i++) r_tab[i] <= 3'b100;
    end else if (i_wr_en && r_state == IDLE) begin
      r_tab[i_wr_addr] <= i_wr_data;
    end
  end
  assign o_note_sel = r_note;
  assign o_gate = r_gate;
  assign o_step = r_step;
  assign o_busy = r_busy;
  assign o_done = r_done;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed and random checks of note_sequencer against a behavioural model.
module tb_note_sequencer;
  localparam int S = 10;
  localparam int G = 2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
  logic [3:0] last_step = '0, wr_addr = '0, step;
  logic [2:0] wr_data = '0;
  logic [1:0] note;
  logic gate, busy, done;
  int n_err = 0, n_chk = 0;
  logic [2:0] m_tab [16];
  bit m_play, m_rest, m_done;
  int m_step, m_cnt, m_last;
  logic [1:0] m_note;

  note_sequencer #(.STEP_CYCLES(S), .GAP_CYCLES(G), .PATTERN_LEN(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_loop(loop),
    .i_last_step(last_step), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_note_sel(note), .o_gate(gate), .o_step(step), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_tab[i] = 3'b100;
    m_play = 0; m_rest = 1; m_done = 0;
    m_step = 0; m_cnt = 0; m_last = 0; m_note = 2'd0;
  endtask

  task automatic load();
    m_rest = m_tab[m_step][2];
    if (!m_rest) m_note = m_tab[m_step][1:0];
  endtask

  task automatic model_next();
    m_done = 0;
    if (!m_play) begin
      if (start && !stop) begin
        m_play = 1; m_last = int'(last_step); m_step = 0; m_cnt = 0;
        load();
      end
      if (wr_en) m_tab[wr_addr] = wr_data;
    end else if (stop) begin
      m_play = 0; m_step = 0; m_cnt = 0;
    end else if (m_cnt == S - 1) begin
      m_cnt = 0;
      if (m_step < m_last) begin m_step++; load(); end
      else if (loop) begin m_step = 0; load(); end
      else begin m_play = 0; m_step = 0; m_done = 1; end
    end else m_cnt++;
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
    chk("note", 32'(note), 32'(m_note));
    chk("gate", 32'(gate), 32'(m_play && !m_rest && m_cnt < S - G));
    chk("step", 32'(step), 32'(m_step));
    chk("busy", 32'(busy), 32'(m_play));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1; wr_addr = 4'(a); wr_data = 3'(d);
    tick();
    wr_en = 0;
  endtask

  task automatic play(input int ls, input bit lp);
    last_step = 4'(ls); loop = lp; start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    model_reset();
    #22 rst = 0;
    // asynchronous reset in the middle of a playing pattern
    wr(0, 1);
    play(0, 1);
    repeat (4) tick();
    #3 rst = 1;
    #1;
    chk("rst_note", 32'(note), 0);
    chk("rst_gate", 32'(gate), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    model_reset();
    @(negedge clk) rst = 0;
    repeat (3) begin
      tick();
      chk("idle_gate", 32'(gate), 0);
      chk("idle_busy", 32'(busy), 0);
    end
    // one-shot 0,1,2,3
    for (int i = 0; i < 4; i++) wr(i, i);
    play(3, 0);
    chk("os_note0", 32'(note), 0);
    chk("os_gate1", 32'(gate), 1);
    for (int k = 2; k <= 42; k++) begin
      tick();
      if (k == 8) chk("os_gate8", 32'(gate), 1);
      if (k == 9 || k == 10) chk("os_gap", 32'(gate), 0);
      if (k == 11) chk("os_note1", 32'(note), 1);
      if (k == 21) chk("os_note2", 32'(note), 2);
      if (k == 31) chk("os_note3", 32'(note), 3);
      if (k == 40) chk("os_nodone", 32'(done), 0);
      if (k == 41) begin chk("os_done", 32'(done), 1); chk("os_busy", 32'(busy), 0); end
      if (k == 42) chk("os_done1cyc", 32'(done), 0);
    end
    // rest entry keeps the previous note and mutes the whole step
    wr(0, 2); wr(1, 4); wr(2, 3);
    play(2, 0);
    chk("rest_note0", 32'(note), 2);
    for (int k = 2; k <= 32; k++) begin
      tick();
      if (k >= 11 && k <= 20) begin chk("rest_gate", 32'(gate), 0); chk("rest_hold", 32'(note), 2); end
      if (k == 21) chk("rest_note2", 32'(note), 3);
    end
    // looping two-step pattern, loop dropped during the second pass
    play(1, 1);
    for (int k = 2; k <= 42; k++) begin
      loop = (k < 35);
      tick();
      if (k == 11) chk("lp_step1", 32'(step), 1);
      if (k == 21) chk("lp_step0", 32'(step), 0);
      if (k == 31) chk("lp_step1b", 32'(step), 1);
      if (k < 41) chk("lp_nodone", 32'(done), 0);
      if (k == 41) chk("lp_done", 32'(done), 1);
    end
    // stop mid-pattern, then start and stop together
    wr(0, 1); wr(1, 2);
    play(1, 1);
    for (int k = 2; k <= 16; k++) begin
      stop = (k == 16);
      tick();
    end
    stop = 0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_gate", 32'(gate), 0);
    chk("stop_step", 32'(step), 0);
    chk("stop_done", 32'(done), 0);
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    chk("both_busy", 32'(busy), 0);
    // write lockout while playing, write honoured while idle
    wr(0, 1);
    play(0, 1);
    for (int k = 2; k <= 11; k++) begin
      wr_en = (k == 5); wr_addr = 4'd0; wr_data = 3'd3;
      tick();
    end
    wr_en = 0;
    chk("lock_note", 32'(note), 1);
    stop = 1; tick(); stop = 0;
    wr(0, 3);
    play(0, 0);
    chk("idle_wr_note", 32'(note), 3);
    repeat (12) tick();
    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      start = ($urandom_range(0, 15) == 0);
      stop = ($urandom_range(0, 63) == 0);
      loop = ($urandom_range(0, 3) != 0);
      last_step = 4'($urandom_range(0, 15));
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 3'($urandom_range(0, 7));
      tick();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
